// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults for the scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_def_addr_width = 5;
    localparam int c_def_data_width = 32;
    localparam int c_def_nr_read    = 2;

    // Register index 0 is hardwired to zero and can never be pending
    localparam int c_zero_idx       = 0;

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One combinational read port: zero-index masking, write
//               forwarding mux and busy masking.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = c_def_addr_width,
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    input  logic                  i_pend,
    input  logic                  i_wr_act,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] c_zero_addr = ADDR_WIDTH'(c_zero_idx);

    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = (i_raddr == c_zero_addr);
    // i_wr_act already excludes index 0 and reset, so a hit is always a real write
    assign w_hit     = (BYPASS != 0) && i_wr_act && (i_waddr == i_raddr);

    // Select read data and busy: zero register first, then forwarded write, then storage
    always_comb begin
        o_rdata = i_rf_data;
        o_busy  = i_pend;
        if (w_is_zero) begin
            o_rdata = '0;
            o_busy  = 1'b0;
        end else if (w_hit) begin
            o_rdata = i_wdata;
            o_busy  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Multi-read-port register file with a pending-write
//               scoreboard, zero register and optional write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = c_def_addr_width,
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int NR_READ    = c_def_nr_read,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NR_READ*DATA_WIDTH-1:0] rdata,
    output logic [NR_READ-1:0]            busy,
    input  logic                          alloc_valid,
    input  logic [ADDR_WIDTH-1:0]         alloc_addr,
    output logic                          alloc_ready
);

    localparam int                    c_depth     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_zero_addr = ADDR_WIDTH'(c_zero_idx);

    logic [DATA_WIDTH-1:0] r_rf [c_depth];
    logic [c_depth-1:0]    r_pend;

    logic w_wr_act;
    logic w_alloc_fire;

    // Qualified write: gated by reset so forwarding cannot expose wdata while rst is low
    assign w_wr_act     = rst && wen && (waddr != c_zero_addr);

    // A pending destination may be re-allocated in the cycle its writeback lands
    assign alloc_ready  = !r_pend[alloc_addr]
                        || (wen && (waddr == alloc_addr))
                        || (alloc_addr == c_zero_addr);
    assign w_alloc_fire = alloc_valid && alloc_ready && (alloc_addr != c_zero_addr);

    // Register storage; index 0 is never written and stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_act) begin
            r_rf[waddr] <= wdata;
        end
    end

    // Scoreboard: writeback clears, allocation sets; the later assignment lets set win
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            if (wen) begin
                r_pend[waddr] <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_pend[alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NR_READ; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_idx;
        assign w_idx = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

        regfile_rd_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .BYPASS     (BYPASS)
        ) u_rd_port (
            .i_raddr   (w_idx),
            .i_rf_data (r_rf[w_idx]),
            .i_pend    (r_pend[w_idx]),
            .i_wr_act  (w_wr_act),
            .i_waddr   (waddr),
            .i_wdata   (wdata),
            .o_rdata   (rdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_busy    (busy[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb (defaults, 2 read ports).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  busy;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_addr = '0;
    logic        alloc_ready;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t r_q[$];

    logic [31:0] m_rf   [32];
    logic        m_pend [32];

    regfile_sb u_dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .busy        (busy),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want normal end");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            0:       return rdata[31:0];
            1:       return rdata[63:32];
            2:       return {30'b0, busy};
            default: return {31'b0, alloc_ready};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        r_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        while (r_q.size() > 0) begin
            e = r_q.pop_front();
            chk(e.tag, get_out(e.sel), e.exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic av, input logic [4:0] aa);
        wen         = w;
        waddr       = wa;
        wdata       = wd;
        raddr       = {r1, r0};
        alloc_valid = av;
        alloc_addr  = aa;
    endtask

    // Model of one read port: {busy, data}
    function automatic logic [32:0] m_port(input logic [4:0] idx, input logic w,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 5'd0)           return 33'd0;
        if (w && (wa == idx))      return {1'b0, wd};
        return {m_pend[idx], m_rf[idx]};
    endfunction

    initial begin
        // In reset: a write and alloc are presented but must have no visible effect
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, 1'b1, 5'd6);
        push("rst_rd0", 0, 32'h0);
        push("rst_rd1", 1, 32'h0);
        push("rst_busy", 2, 32'h0);
        push("rst_rdy", 3, 32'h1);
        #1 sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        rst = 1'b1;

        // Write discarded during reset, then write/read of index 5 with forwarding
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd6);
        push("post_rst_rd5", 0, 32'h0);
        push("post_rst_rdy6", 3, 32'h1);
        #1 sample();
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd5, 1'b0, 5'd0);
        push("wr5_fwd_rd1", 1, 32'hDEAD_BEEF);
        push("wr5_rd0_zero", 0, 32'h0);
        #1 sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
        push("rd5", 0, 32'hDEAD_BEEF);
        #1 sample();

        // Zero register: write and alloc to 0 are ignored
        @(negedge clk);
        drive(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b1, 5'd0);
        push("z_rd0", 0, 32'h0);
        push("z_rd1", 1, 32'h0);
        push("z_busy", 2, 32'h0);
        push("z_rdy", 3, 32'h1);
        #1 sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        push("z_rd0_after", 0, 32'h0);
        push("z_busy_after", 2, 32'h0);
        #1 sample();

        // Bypass on port 1
        @(negedge clk);
        drive(1'b1, 5'd7, 32'hA5, 5'd0, 5'd7, 1'b0, 5'd0);
        push("byp_rd1", 1, 32'hA5);
        push("byp_busy", 2, 32'h0);
        #1 sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0);
        push("byp_rd1_stored", 1, 32'hA5);
        #1 sample();

        // Scoreboard and stall on index 9
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
        push("sb_alloc1_rdy", 3, 32'h1);
        push("sb_alloc1_busy", 2, 32'h0);
        #1 sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
        push("sb_busy9", 2, 32'h1);
        push("sb_alloc2_stall", 3, 32'h0);
        #1 sample();
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 1'b1, 5'd9);
        push("sb_wr_alloc_rdy", 3, 32'h1);
        push("sb_wr_alloc_busy", 2, 32'h0);
        push("sb_wr_alloc_rd", 0, 32'h99);
        #1 sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd9);
        push("sb_set_wins_busy", 2, 32'h1);
        push("sb_set_wins_rdy", 3, 32'h0);
        push("sb_set_wins_rd", 0, 32'h99);
        #1 sample();
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h100, 5'd9, 5'd0, 1'b0, 5'd0);
        push("sb_lone_wr_busy", 2, 32'h0);
        #1 sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd9);
        push("sb_cleared_busy", 2, 32'h0);
        push("sb_cleared_rdy", 3, 32'h1);
        push("sb_cleared_rd", 0, 32'h100);
        #1 sample();

        // Write to a non-pending register leaves the scoreboard alone
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h55, 5'd0, 5'd0, 1'b0, 5'd5);
        push("np_wr_rdy", 3, 32'h1);
        #1 sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd5);
        push("np_rd", 0, 32'h55);
        push("np_busy", 2, 32'h0);
        push("np_rdy", 3, 32'h1);
        #1 sample();

        // Reset mid-operation: 3 written, 4 written and pending
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 1'b1, 5'd4);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b0, 5'd4);
        push("mid_rd3", 0, 32'h33);
        push("mid_rd4", 1, 32'h44);
        push("mid_busy", 2, 32'h2);
        push("mid_rdy4", 3, 32'h0);
        #1 sample();
        #2 rst = 1'b0;
        #1;
        push("arst_rd3", 0, 32'h0);
        push("arst_rd4", 1, 32'h0);
        push("arst_busy", 2, 32'h0);
        push("arst_rdy", 3, 32'h1);
        sample();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b0, 5'd4);
        push("rel_rd3", 0, 32'h0);
        push("rel_rd4", 1, 32'h0);
        push("rel_busy", 2, 32'h0);
        push("rel_rdy4", 3, 32'h1);
        #1 sample();

        // Randomised traffic on a small index range against a behavioural model
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'h0;
            m_pend[i] = 1'b0;
        end
        for (int n = 0; n < 60; n++) begin
            logic        w, av, rdy;
            logic [4:0]  wa, r0, r1, aa;
            logic [31:0] wd;
            logic [32:0] p0, p1;
            @(negedge clk);
            w  = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 7));
            wd = $urandom;
            r0 = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            av = 1'($urandom_range(0, 1));
            aa = 5'($urandom_range(0, 7));
            drive(w, wa, wd, r0, r1, av, aa);
            p0  = m_port(r0, w, wa, wd);
            p1  = m_port(r1, w, wa, wd);
            rdy = !m_pend[aa] || (w && (wa == aa)) || (aa == 5'd0);
            push("rnd_rd0", 0, p0[31:0]);
            push("rnd_rd1", 1, p1[31:0]);
            push("rnd_busy", 2, {30'b0, p1[32], p0[32]});
            push("rnd_rdy", 3, {31'b0, rdy});
            #1 sample();
            if (w && (wa != 5'd0)) m_rf[wa] = wd;
            if (w)                 m_pend[wa] = 1'b0;
            if (av && rdy && (aa != 5'd0)) m_pend[aa] = 1'b1;
        end

        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
